// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
package dmem_pkg;

  localparam int unsigned DMEM_DEPTH_WORDS = 256;
  localparam int unsigned DMEM_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

endpackage

// File: rtl/dmem_array.sv
// Word storage with byte-lane writes; the read word is captured on the access edge.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter int unsigned IDX_W       = 8
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  input  logic [3:0]       be,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, WAIT_CYCLES wait states, range check.
// Define DMEM_ALIGN_CHECK_EN to reject accesses whose addr[1:0] is non-zero.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter int unsigned WAIT_CYCLES = DMEM_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t      state, state_next;
  logic [3:0]  cnt;
  req_t        req_q, acc_req;
  logic        err_q;
  logic        accept, access, acc_err;
  logic [31:0] arr_rdata;

  assign accept = (state == IDLE) && req_valid;

  // With no wait states the access happens on the accepting edge, so use the live request.
  always_comb begin
    acc_req = req_q;
    if (state == IDLE) acc_req = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
  end

  assign access = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == 4'd1));

`ifdef DMEM_ALIGN_CHECK_EN
  assign acc_err = ({2'b00, acc_req.addr[31:2]} >= DEPTH_WORDS) || (acc_req.addr[1:0] != 2'b00);
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^acc_req.addr[1:0];
  assign acc_err = ({2'b00, acc_req.addr[31:2]} >= DEPTH_WORDS);
`endif

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk),
    .en   (access && !acc_err),
    .we   (acc_req.we),
    .idx  (acc_req.addr[IDX_W+1:2]),
    .wdata(acc_req.wdata),
    .be   (acc_req.be),
    .rdata(arr_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      req_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        req_q <= acc_req;
        cnt   <= 4'(WAIT_CYCLES);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (access) err_q <= acc_err;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt == 4'd1) state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Stores and rejected accesses report zero data regardless of the array output.
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !err_q && !req_q.we) ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver queues expected responses, monitor checks them.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int WAIT  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  logic first = 1'b1;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(WAIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every RESP cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      first = 1'b1;
    end else if (rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", {31'b0, rsp_valid}, 32'd0);
      end else begin
        if (first) begin
          chk("latency", 32'(cyc - sb[0].acc_cyc + 1), 32'(WAIT + 1));
          first = 1'b0;
        end
        chk("rsp_rdata", rsp_rdata, sb[0].rdata);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, sb[0].err});
        chk("req_ready_in_resp", {31'b0, req_ready}, 32'd0);
        if (rsp_ready) begin
          void'(sb.pop_front());
          first = 1'b1;
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    @(posedge clk);
    #1;
    sb.push_back('{rdata: exp_rdata, err: exp_err, acc_cyc: cyc});
    // Garbage on the request bus while busy must be ignored.
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("rsp_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err);
    issue(we, addr, wdata, be, exp_rdata, exp_err);
    drain();
  endtask

  initial begin
    #1;
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'b0, req_ready}, 32'd1);

    // Full store / load, then single-lane merge.
    xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0);
    xfer(1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0);
    xfer(1'b1, 32'h10, 32'h000000AA, 4'b0001, 32'h0, 1'b0);
    xfer(1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEAA, 1'b0);

`ifdef DMEM_ALIGN_CHECK_EN
    xfer(1'b0, 32'h13, 32'h0, 4'b0000, 32'h0, 1'b1);
`else
    xfer(1'b0, 32'h13, 32'h0, 4'b0000, 32'hDEADBEAA, 1'b0);
`endif

    // be=0000 store is a no-op; be=1010 touches lanes 1 and 3 only.
    xfer(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0);
    xfer(1'b0, 32'h10, 32'h0, 4'b1111, 32'hDEADBEAA, 1'b0);
    xfer(1'b1, 32'h10, 32'h11223344, 4'b1010, 32'h0, 1'b0);
    xfer(1'b0, 32'h10, 32'h0, 4'b0000, 32'h11AD33AA, 1'b0);

    // Range boundary: last word legal, index 256 rejected and must not alias word 0.
    xfer(1'b1, 32'h3FC, 32'h5A5A0FF0, 4'b1111, 32'h0, 1'b0);
    xfer(1'b0, 32'h3FC, 32'h0, 4'b0000, 32'h5A5A0FF0, 1'b0);
    xfer(1'b1, 32'h0, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0);
    xfer(1'b1, 32'h400, 32'h12345678, 4'b1111, 32'h0, 1'b1);
    xfer(1'b0, 32'h400, 32'h0, 4'b0000, 32'h0, 1'b1);
    xfer(1'b0, 32'h0, 32'h0, 4'b0000, 32'hCAFEF00D, 1'b0);

    // Backpressure: response held while req_valid pulses with a store to the same word.
    rsp_ready = 1'b0;
    issue(1'b0, 32'h10, 32'h0, 4'b0000, 32'h11AD33AA, 1'b0);
    for (int i = 0; i < WAIT + 5; i++) begin
      @(negedge clk);
      req_valid = (i % 2 == 0);
      req_we    = 1'b1;
      req_addr  = 32'h10;
      req_wdata = 32'h0;
      req_be    = 4'b1111;
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();
    xfer(1'b0, 32'h10, 32'h0, 4'b0000, 32'h11AD33AA, 1'b0);

    // Reset one edge before a pending store would be performed.
    xfer(1'b1, 32'h20, 32'h11223344, 4'b1111, 32'h0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'hFFFFFFFF;
    req_be    = 4'b1111;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (WAIT) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("abort_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("abort_rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);
    xfer(1'b0, 32'h20, 32'h0, 4'b0000, 32'h11223344, 1'b0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
